// File: rtl/comp4bb.sv
// -----------------------------------------------------------------------------
// comp4bb -- registered magnitude comparator
//
// Compares two WIDTH-bit operands every rising clock edge and registers three
// mutually exclusive flags. Output latency is exactly one clock, and there is
// no combinational path from the operands to the outputs, so the flags are
// glitch-free.
//
// Parameters
//   WIDTH   operand width in bits (>= 1)
//   SIGNED  0: unsigned compare; 1: two's-complement compare (MSB is sign)
//
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous, active-high reset; clears all flags
//   l     out  1      registered A <  B
//   g     out  1      registered A >  B
//   e     out  1      registered A == B
//   A     in   WIDTH  operand A
//   B     in   WIDTH  operand B
//
// While the block is in reset, and during the first cycle after reset is
// released, all three flags are 0 ("no result yet"). After the first
// post-reset edge exactly one flag is set.
// -----------------------------------------------------------------------------
module comp4bb #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             l,
    output logic             g,
    output logic             e,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B
);

    logic lt_next;
    logic gt_next;
    logic eq_next;

    logic l_reg;
    logic g_reg;
    logic e_reg;

    // Equality is a plain bitwise match, independent of signedness.
    assign eq_next = (A == B);

    // Only the ordering compare depends on how the MSB is interpreted.
    generate
        if (SIGNED) begin : g_signed_cmp
            always_comb begin
                lt_next = 1'b0;
                gt_next = 1'b0;
                lt_next = ($signed(A) < $signed(B));
                gt_next = ($signed(A) > $signed(B));
            end
        end else begin : g_unsigned_cmp
            always_comb begin
                lt_next = 1'b0;
                gt_next = 1'b0;
                lt_next = (A < B);
                gt_next = (A > B);
            end
        end
    endgenerate

    // Flags register every cycle; there is deliberately no enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_reg <= 1'b0;
            g_reg <= 1'b0;
            e_reg <= 1'b0;
        end else begin
            l_reg <= lt_next;
            g_reg <= gt_next;
            e_reg <= eq_next;
        end
    end

    assign l = l_reg;
    assign g = g_reg;
    assign e = e_reg;

endmodule

// File: tb/tb_comp4bb.sv
// -----------------------------------------------------------------------------
// tb_comp4bb -- self-checking bench for comp4bb
//
// Two instances share the operand inputs: one unsigned, one signed. Operands
// are driven on the falling edge; expected {l,g,e} values are pushed to a
// queue per instance and popped by a monitor that samples 1 time unit after
// the following rising edge. Unsigned expectations come from a constant
// table; signed expectations come from a small sign-extension model.
// Reset behaviour is checked with hand-written sequences.
// -----------------------------------------------------------------------------
module tb_comp4bb;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       l_u, g_u, e_u;
    logic       l_s, g_s, e_s;

    int n_tests;
    int n_fail;

    logic [2:0] q_u[$];
    logic [2:0] q_s[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] lge;   // expected unsigned {l,g,e}
    } vec_t;

    vec_t vecs[$];

    comp4bb #(.WIDTH(4), .SIGNED(1'b0)) u_dut_u (
        .clk (clk),
        .rst (rst),
        .l   (l_u),
        .g   (g_u),
        .e   (e_u),
        .A   (A),
        .B   (B)
    );

    comp4bb #(.WIDTH(4), .SIGNED(1'b1)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .l   (l_s),
        .g   (g_s),
        .e   (e_s),
        .A   (A),
        .B   (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference for the signed instance: interpret operands as 4-bit two's complement.
    function automatic logic [2:0] model_signed(input logic [3:0] a, input logic [3:0] b);
        int sa;
        int sb;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        return {(sa < sb), (sa > sb), (sa == sb)};
    endfunction

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got lge=%b, expected %b (A=%h B=%h t=%0t)", name, act, exp, A, B, $time);
        end else begin
            $display("ok   %s: lge=%b (A=%h B=%h t=%0t)", name, act, A, B, $time);
        end
    endtask

    // Drive one operand pair now, queue its expectations, wait for the next falling edge.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] exp_u);
        A = a;
        B = b;
        q_u.push_back(exp_u);
        q_s.push_back(model_signed(a, b));
        @(negedge clk);
    endtask

    // Monitor: one result per rising edge while a transaction is outstanding.
    logic [2:0] mon_u;
    logic [2:0] mon_s;
    always @(posedge clk) begin
        if (q_u.size() > 0) begin
            mon_u = q_u.pop_front();
            mon_s = q_s.pop_front();
            #1;
            chk("unsigned", {l_u, g_u, e_u}, mon_u);
            chk("signed",   {l_s, g_s, e_s}, mon_s);
            chk("onehot_u", {2'b00, $onehot({l_u, g_u, e_u})}, 3'b001);
            chk("onehot_s", {2'b00, $onehot({l_s, g_s, e_s})}, 3'b001);
        end
    end

    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Stimulus table: steps 2-4 and the signed boundary pairs.
        vecs.push_back('{4'h1, 4'h3, LT});
        vecs.push_back('{4'h1, 4'h4, LT});
        vecs.push_back('{4'h1, 4'h5, LT});
        vecs.push_back('{4'h1, 4'h6, LT});
        vecs.push_back('{4'h5, 4'h0, GT});
        vecs.push_back('{4'h5, 4'h1, GT});
        vecs.push_back('{4'h5, 4'h2, GT});
        vecs.push_back('{4'h5, 4'h3, GT});
        vecs.push_back('{4'h5, 4'h4, GT});
        vecs.push_back('{4'h1, 4'h1, EQ});
        vecs.push_back('{4'h2, 4'h2, EQ});
        vecs.push_back('{4'h3, 4'h3, EQ});
        vecs.push_back('{4'h4, 4'h4, EQ});
        vecs.push_back('{4'h5, 4'h5, EQ});
        vecs.push_back('{4'h0, 4'h0, EQ});
        vecs.push_back('{4'hF, 4'hF, EQ});
        vecs.push_back('{4'hF, 4'h0, GT});
        vecs.push_back('{4'h0, 4'hF, LT});
        vecs.push_back('{4'hF, 4'h1, GT});   // signed: -1 < +1
        vecs.push_back('{4'h8, 4'h7, GT});   // signed: -8 < +7
        vecs.push_back('{4'h7, 4'h8, LT});   // signed: +7 > -8

        rst = 1'b1;
        A   = 4'h0;
        B   = 4'h0;

        // Reset takes effect without a clock edge.
        #2;
        chk("reset_async_u", {l_u, g_u, e_u}, 3'b000);
        chk("reset_async_s", {l_s, g_s, e_s}, 3'b000);
        @(posedge clk);
        #1;
        chk("reset_edge_u", {l_u, g_u, e_u}, 3'b000);

        // Release reset; flags stay cleared until the first edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_release_u", {l_u, g_u, e_u}, 3'b000);
        chk("post_release_s", {l_s, g_s, e_s}, 3'b000);

        // First edge after release: A=1, B=2.
        drive(4'h1, 4'h2, LT);

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].lge);
        end

        // Asynchronous reset between edges while g=1.
        drive(4'h9, 4'h2, GT);
        #1;
        chk("pre_rst_g", {l_u, g_u, e_u}, GT);
        rst = 1'b1;
        #1;
        chk("mid_rst_u", {l_u, g_u, e_u}, 3'b000);
        chk("mid_rst_s", {l_s, g_s, e_s}, 3'b000);
        @(posedge clk);
        #1;
        chk("mid_rst_edge_u", {l_u, g_u, e_u}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rerelease_u", {l_u, g_u, e_u}, 3'b000);
        drive(4'hF, 4'h0, GT);
        drive(4'h3, 4'hC, LT);

        // Drain outstanding transactions with a bounded wait.
        for (int k = 0; k < 8 && q_u.size() > 0; k++) begin
            @(posedge clk);
        end
        #2;
        if (q_u.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d results still outstanding, required 0", q_u.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
